// File: rtl/toe_pkg.sv
// toe_pkg: shared constants and types for the TCP header streamer.
//   ETH_TYPE_IPV4 / IP_PROTO_TCP : protocol constants placed in the header
//   HDR_BYTES / HDR_WORDS        : header size in bytes and in 32-bit words
//   rec_word_e                   : word offsets inside a connection record
//   state_e                      : streamer FSM states
package toe_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP  = 8'h06;
  localparam int          HDR_BYTES     = 54;
  localparam int          HDR_WORDS     = 14;
  localparam int          REC_WORDS     = 9;

  typedef enum logic [3:0] {
    REC_CTRL       = 4'd0,  // {valid, rsvd, window}
    REC_SEQ        = 4'd1,
    REC_ACK        = 4'd2,
    REC_IP_SRC     = 4'd3,
    REC_IP_DST     = 4'd4,
    REC_MAC_SRC_HI = 4'd5,  // mac_src[47:16]
    REC_MAC_MIX    = 4'd6,  // {mac_src[15:0], mac_dst[47:32]}
    REC_MAC_DST_LO = 4'd7,  // mac_dst[31:0]
    REC_PORTS      = 4'd8   // {src_port, dst_port}
  } rec_word_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_CSUM,
    ST_EMIT,
    ST_DROP
  } state_e;

endpackage

// File: rtl/csum16_fold.sv
// csum16_fold: combinational one's-complement sum of ten 16-bit halfwords
// with end-around carry folded back into 16 bits (result is not inverted).
//   hw  in  160  halfwords, hw[159:144] first
//   sum out 16   folded one's-complement sum
module csum16_fold (
  input  logic [159:0] hw,
  output logic [15:0]  sum
);

  logic [19:0] raw;
  logic [16:0] fold1;

  always_comb begin
    raw = '0;
    for (int i = 0; i < 10; i++) begin
      raw = raw + {4'h0, hw[159 - 16*i -: 16]};
    end
  end

  // Ten halfwords carry at most 4 bits; two folds absorb every carry.
  assign fold1 = {1'b0, raw[15:0]} + {13'h0, raw[19:16]};
  assign sum   = fold1[15:0] + {15'h0, fold1[16]};

endmodule

// File: rtl/tcp_hdr_streamer.sv
// tcp_hdr_streamer: fetches one connection record from the connection RAM,
// checks its valid bit and streams a 54-byte Ethernet/IPv4/TCP header as
// big-endian 32-bit words under valid/ready.
// Optional feature macro: TCP_HDR_IPCSUM_EN (adds a CSUM state and fills the
// IPv4 header checksum; otherwise the checksum field is sent as 0x0000).
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              build request handshake
//   req_conn/req_flags/req_pay_len   connection index, TCP flags, payload bytes
//   ram_addr/ram_rdata               connection RAM read port (RAM_LAT latency)
//   hdr_data/hdr_valid/hdr_ready     header word stream, byte0 in [31:24]
//   hdr_last/hdr_nbytes              final word marker, valid bytes in word
//   drop_pulse                       request discarded (invalid record)
//   busy                             FSM not idle
module tcp_hdr_streamer
  import toe_pkg::*;
#(
  parameter int NUM_CONN   = 8,
  parameter int REC_STRIDE = 16,
  parameter int ADDR_W     = 9,
  parameter int RAM_LAT    = 1,
  parameter int IP_TTL     = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_CONN)-1:0] req_conn,
  input  logic [7:0]                  req_flags,
  input  logic [15:0]                 req_pay_len,
  output logic [ADDR_W-1:0]           ram_addr,
  input  logic [31:0]                 ram_rdata,
  output logic [31:0]                 hdr_data,
  output logic                        hdr_valid,
  input  logic                        hdr_ready,
  output logic                        hdr_last,
  output logic [2:0]                  hdr_nbytes,
  output logic                        drop_pulse,
  output logic                        busy
);

  localparam int         CONN_W      = $clog2(NUM_CONN);
  localparam int         HDR_BITS    = HDR_WORDS * 32;
  localparam logic [2:0] LAST_NBYTES = 3'(HDR_BYTES - 4*(HDR_WORDS-1));
  localparam logic [3:0] LAST_WIDX   = 4'(HDR_WORDS - 1);
  localparam logic [3:0] LAST_REC    = 4'(REC_WORDS - 1);
  localparam logic [3:0] FETCH_END   = 4'(REC_WORDS - 1 + RAM_LAT);

  state_e              state;
  logic [3:0]          cyc;
  logic [3:0]          widx;
  logic [3:0]          cap_idx;
  logic [31:0]         rec [REC_WORDS];
  logic [CONN_W-1:0]   conn_q;
  logic [7:0]          flags_q;
  logic [15:0]         pay_len_q;
  logic [15:0]         ip_id;
  logic [15:0]         total_len;
  logic [15:0]         csum_field;
  logic [ADDR_W-1:0]   base_addr;
  logic [47:0]         mac_dst;
  logic [47:0]         mac_src;
  logic [HDR_BITS-1:0] hdr_vec;
  logic [31:0]         hdr_words [HDR_WORDS];
  logic                rec_bad;

  assign base_addr = ADDR_W'(int'(req_conn) * REC_STRIDE);
  assign cap_idx   = cyc - 4'(RAM_LAT);
  assign total_len = pay_len_q + 16'd40;
  assign mac_dst   = {rec[REC_MAC_MIX][15:0], rec[REC_MAC_DST_LO]};
  assign mac_src   = {rec[REC_MAC_SRC_HI], rec[REC_MAC_MIX][31:16]};
  assign rec_bad   = !rec[REC_CTRL][31] ||
                     ({1'b0, conn_q} >= (CONN_W+1)'(NUM_CONN));

`ifdef TCP_HDR_IPCSUM_EN
  logic [15:0] csum_q;
  logic [15:0] csum_sum;

  // Checksum field is taken as zero while summing.
  csum16_fold u_csum (
    .hw  ({16'h4500, total_len, ip_id, 16'h4000, 8'(IP_TTL), IP_PROTO_TCP,
           16'h0000, rec[REC_IP_SRC], rec[REC_IP_DST]}),
    .sum (csum_sum)
  );
  assign csum_field = csum_q;
`else
  assign csum_field = 16'h0000;
`endif

  // Last two bytes of the final word are padding.
  assign hdr_vec = {mac_dst, mac_src, ETH_TYPE_IPV4,
                    8'h45, 8'h00, total_len, ip_id, 16'h4000,
                    8'(IP_TTL), IP_PROTO_TCP, csum_field,
                    rec[REC_IP_SRC], rec[REC_IP_DST],
                    rec[REC_PORTS], rec[REC_SEQ], rec[REC_ACK],
                    8'h50, flags_q, rec[REC_CTRL][15:0], 16'h0000, 16'h0000,
                    16'h0000};

  always_comb begin
    for (int i = 0; i < HDR_WORDS; i++) begin
      hdr_words[i] = hdr_vec[HDR_BITS - 1 - 32*i -: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cyc        <= '0;
      widx       <= '0;
      conn_q     <= '0;
      flags_q    <= '0;
      pay_len_q  <= '0;
      ip_id      <= '0;
      ram_addr   <= '0;
      hdr_data   <= '0;
      hdr_valid  <= 1'b0;
      hdr_last   <= 1'b0;
      hdr_nbytes <= '0;
      drop_pulse <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      for (int i = 0; i < REC_WORDS; i++) rec[i] <= '0;
`ifdef TCP_HDR_IPCSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            conn_q    <= req_conn;
            flags_q   <= req_flags;
            pay_len_q <= req_pay_len;
            ram_addr  <= base_addr;
            cyc       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end

        // Address for word k goes out when cyc==k; its data returns RAM_LAT
        // cycles later, so capture index trails cyc by RAM_LAT.
        ST_FETCH: begin
          cyc <= cyc + 4'd1;
          if (cyc < LAST_REC) ram_addr <= ram_addr + ADDR_W'(1);
          if (cyc >= 4'(RAM_LAT)) rec[cap_idx] <= ram_rdata;
          if (cyc == FETCH_END) state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (rec_bad) begin
            drop_pulse <= 1'b1;
            state      <= ST_DROP;
          end else begin
`ifdef TCP_HDR_IPCSUM_EN
            state      <= ST_CSUM;
`else
            hdr_data   <= hdr_words[0];
            hdr_valid  <= 1'b1;
            hdr_last   <= 1'b0;
            hdr_nbytes <= 3'd4;
            widx       <= '0;
            state      <= ST_EMIT;
`endif
          end
        end

        ST_CSUM: begin
`ifdef TCP_HDR_IPCSUM_EN
          csum_q     <= ~csum_sum;
`endif
          // Word 0 is MAC-only, so it does not depend on the checksum.
          hdr_data   <= hdr_words[0];
          hdr_valid  <= 1'b1;
          hdr_last   <= 1'b0;
          hdr_nbytes <= 3'd4;
          widx       <= '0;
          state      <= ST_EMIT;
        end

        ST_EMIT: begin
          if (hdr_ready) begin
            if (widx == LAST_WIDX) begin
              hdr_data   <= '0;
              hdr_valid  <= 1'b0;
              hdr_last   <= 1'b0;
              hdr_nbytes <= '0;
              ip_id      <= ip_id + 16'd1;
              req_ready  <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              widx       <= widx + 4'd1;
              hdr_data   <= hdr_words[widx + 4'd1];
              hdr_last   <= (widx + 4'd1 == LAST_WIDX);
              hdr_nbytes <= (widx + 4'd1 == LAST_WIDX) ? LAST_NBYTES : 3'd4;
            end
          end
        end

        ST_DROP: begin
          drop_pulse <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_hdr_streamer.sv
module tb_tcp_hdr_streamer;

  localparam int NUM_CONN   = 8;
  localparam int REC_STRIDE = 16;
  localparam int ADDR_W     = 9;
  localparam int RAM_LAT    = 1;
  localparam int IP_TTL     = 64;
`ifdef TCP_HDR_IPCSUM_EN
  localparam int EXP_LAT    = 13;
`else
  localparam int EXP_LAT    = 12;
`endif

  logic                        clk;
  logic                        rst_n;
  logic                        req_valid;
  logic                        req_ready;
  logic [$clog2(NUM_CONN)-1:0] req_conn;
  logic [7:0]                  req_flags;
  logic [15:0]                 req_pay_len;
  logic [ADDR_W-1:0]           ram_addr;
  logic [31:0]                 ram_rdata;
  logic [31:0]                 hdr_data;
  logic                        hdr_valid;
  logic                        hdr_ready;
  logic                        hdr_last;
  logic [2:0]                  hdr_nbytes;
  logic                        drop_pulse;
  logic                        busy;

  tcp_hdr_streamer #(
    .NUM_CONN(NUM_CONN), .REC_STRIDE(REC_STRIDE), .ADDR_W(ADDR_W),
    .RAM_LAT(RAM_LAT), .IP_TTL(IP_TTL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_conn(req_conn),
    .req_flags(req_flags), .req_pay_len(req_pay_len),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .hdr_data(hdr_data), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_last(hdr_last), .hdr_nbytes(hdr_nbytes),
    .drop_pulse(drop_pulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Connection RAM model with RAM_LAT read latency.
  logic [31:0] mem  [2**ADDR_W];
  logic [31:0] pipe [RAM_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RAM_LAT-1];

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  nbytes;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          drops_exp = 0;
  int          drops_seen = 0;
  int          words_popped = 0;
  int          ready_mode = 0;
  logic [15:0] ip_id_model = 16'h0000;
  logic [31:0] cur_rec [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: lay the header out byte by byte from the field definitions.
  function automatic void model_push(input logic [31:0] r [9], input logic [7:0] flags,
                                     input logic [15:0] len, input logic [15:0] id);
    logic [7:0]  b [56];
    logic [47:0] mac_d, mac_s;
    logic [15:0] tl;
    int          sum;
    exp_t        e;
    mac_d = {r[6][15:0], r[7]};
    mac_s = {r[5], r[6][31:16]};
    tl    = len + 16'd40;
    for (int i = 0; i < 56; i++) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]   = mac_d[47-8*i -: 8];
      b[6+i] = mac_s[47-8*i -: 8];
    end
    b[12] = 8'h08; b[14] = 8'h45;
    b[16] = tl[15:8]; b[17] = tl[7:0];
    b[18] = id[15:8]; b[19] = id[7:0];
    b[20] = 8'h40; b[22] = 8'(IP_TTL); b[23] = 8'd6;
    for (int i = 0; i < 4; i++) begin
      b[26+i] = r[3][31-8*i -: 8];
      b[30+i] = r[4][31-8*i -: 8];
      b[34+i] = r[8][31-8*i -: 8];
      b[38+i] = r[1][31-8*i -: 8];
      b[42+i] = r[2][31-8*i -: 8];
    end
    b[46] = 8'h50; b[47] = flags;
    b[48] = r[0][15:8]; b[49] = r[0][7:0];
`ifdef TCP_HDR_IPCSUM_EN
    sum = 0;
    for (int k = 0; k < 10; k++) sum += int'({b[14+2*k], b[15+2*k]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
    sum = (~sum) & 32'hFFFF;
    b[24] = 8'(sum >>> 8);
    b[25] = 8'(sum);
`endif
    for (int w = 0; w < 14; w++) begin
      e.data   = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      e.last   = (w == 13);
      e.nbytes = (w == 13) ? 3'd2 : 3'd4;
      exp_q.push_back(e);
    end
  endfunction

  // Sink ready pattern: 0 always ready, 1 toggling, 2 random.
  initial begin
    hdr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       hdr_ready = 1'b1;
        1:       hdr_ready = ~hdr_ready;
        default: hdr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word, checks stall hold.
  logic        prev_stall = 1'b0;
  logic [35:0] prev_word  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {hdr_valid, hdr_data, hdr_last, hdr_nbytes},
                          {1'b1, prev_word});
      if (hdr_valid && hdr_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %08h with no expected word", hdr_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("hdr_word", {hdr_data, hdr_last, hdr_nbytes}, {e.data, e.last, e.nbytes});
        end
        words_popped++;
      end
      if (drop_pulse) drops_seen++;
      prev_stall = hdr_valid && !hdr_ready;
      prev_word  = {hdr_data, hdr_last, hdr_nbytes};
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    chk("req_ready_timeout", {63'h0, req_ready}, 64'h1);
  endtask

  task automatic write_rec(input int conn);
    for (int i = 0; i < 9; i++) mem[conn*REC_STRIDE + i] = cur_rec[i];
  endtask

  task automatic gen_rec(input int conn, input bit vld);
    for (int i = 0; i < 9; i++) cur_rec[i] = $urandom;
    cur_rec[0][31] = vld;
    write_rec(conn);
  endtask

  // Call at a negedge with the DUT idle. hold > 0 keeps req_valid (with junk
  // fields) asserted for that many extra cycles while the DUT is busy.
  task automatic issue(input int conn, input logic [7:0] flags, input logic [15:0] len,
                       input bit check_lat, input int hold);
    int n;
    if (cur_rec[0][31]) begin
      model_push(cur_rec, flags, len, ip_id_model);
      ip_id_model++;
    end else begin
      drops_exp++;
    end
    req_conn = 3'(conn); req_flags = flags; req_pay_len = len; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_flags = ~flags; req_pay_len = ~len; req_conn = 3'($urandom_range(0, 7));
    if (hold == 0) req_valid = 1'b0;
    if (check_lat) begin
      n = 0;
      while (n < 40) begin
        @(negedge clk);
        n++;
        if (n <= 9) chk("ram_addr", 64'(ram_addr), 64'(conn*REC_STRIDE + n - 1));
        if (hdr_valid) break;
      end
      chk("first_word_latency", 64'(n), 64'(EXP_LAT));
    end else begin
      for (int i = 0; i < hold; i++) @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !req_ready || busy) && n < 600) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", {62'h0, req_ready, busy}, 64'h2);
    chk("drop_count", 64'(drops_seen), 64'(drops_exp));
  endtask

  task automatic chk_reset_vals();
    chk("rst_hdr_valid", {63'h0, hdr_valid}, 64'h0);
    chk("rst_hdr_last", {63'h0, hdr_last}, 64'h0);
    chk("rst_hdr_nbytes", 64'(hdr_nbytes), 64'h0);
    chk("rst_hdr_data", 64'(hdr_data), 64'h0);
    chk("rst_ram_addr", 64'(ram_addr), 64'h0);
    chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_drop", {63'h0, drop_pulse}, 64'h0);
  endtask

  initial begin
    int base, n, conn;
    rst_n = 1'b0; req_valid = 1'b0; req_conn = '0; req_flags = '0; req_pay_len = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Directed: connection 3, known MAC destination, 100-byte payload.
    ready_mode = 0;
    wait_ready();
    gen_rec(3, 1'b1);
    cur_rec[6][15:0] = 16'h0A0B;
    cur_rec[7]       = 32'h0C0D0E0F;
    write_rec(3);
    issue(3, 8'h18, 16'd100, 1'b1, 0);
    wait_idle();

    // Invalid record: dropped, ip_id untouched (checked by the next header).
    wait_ready();
    gen_rec(5, 1'b0);
    issue(5, 8'h02, 16'd0, 1'b0, 0);
    wait_idle();
    wait_ready();
    gen_rec(2, 1'b1);
    issue(2, 8'h10, 16'hFFF0, 1'b1, 0);
    wait_idle();

    // Toggling sink ready.
    ready_mode = 1;
    wait_ready();
    gen_rec(3, 1'b1);
    issue(3, 8'h18, 16'd100, 1'b0, 0);
    wait_idle();

    // Random back-to-back traffic, random backpressure, req_valid held while busy.
    ready_mode = 2;
    for (int k = 0; k < 30; k++) begin
      conn = int'($urandom_range(0, NUM_CONN-1));
      wait_ready();
      gen_rec(conn, ($urandom_range(0, 9) < 8));
      issue(conn, 8'($urandom), 16'($urandom), 1'b0, int'($urandom_range(0, 6)));
    end
    wait_idle();

    // Reset while word 6 is on the bus.
    ready_mode = 0;
    wait_ready();
    gen_rec(6, 1'b1);
    base = words_popped;
    issue(6, 8'h11, 16'd7, 1'b0, 0);
    n = 0;
    while (words_popped - base < 6 && n < 100) begin @(negedge clk); n++; end
    chk("reach_word6", 64'(words_popped - base), 64'd6);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    ip_id_model = 16'h0000;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready();
    gen_rec(1, 1'b1);
    base = words_popped;
    issue(1, 8'h12, 16'd1460, 1'b1, 0);
    wait_idle();
    chk("post_reset_words", 64'(words_popped - base), 64'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
